// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants, ALU code encoding and the issue-bundle layout
// handed from the decode stage to the execute stage.
package rv32_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] ALU_ADD  = 5'b01000;
  localparam logic [4:0] ALU_SUB  = 5'b11000;
  localparam logic [4:0] ALU_SLL  = 5'b01001;
  localparam logic [4:0] ALU_SLT  = 5'b01010;
  localparam logic [4:0] ALU_SLTU = 5'b01011;
  localparam logic [4:0] ALU_XOR  = 5'b01100;
  localparam logic [4:0] ALU_SRL  = 5'b01101;
  localparam logic [4:0] ALU_SRA  = 5'b11101;
  localparam logic [4:0] ALU_OR   = 5'b01110;
  localparam logic [4:0] ALU_AND  = 5'b01111;

  localparam int XLEN_W = 32;
  localparam int CODE_W = 6;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic              illegal;
    logic              we;
    logic [RD_W-1:0]   rd;
    logic [XLEN_W-1:0] rv2;
    logic [XLEN_W-1:0] rv1;
    logic [CODE_W-1:0] code;
  } issue_t;

  // code[5] marks immediate-operand forms; code[4:0] = {alt, 1, funct3}.
  function automatic logic [CODE_W-1:0] alu_code(input logic imm_form,
                                                  input logic alt,
                                                  input logic [2:0] f3);
    return {imm_form, alt, 1'b1, f3};
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready buffer; in_ready is registered from the next-state
// occupancy so neither side sees a combinational path through the buffer.
module skid_buf2 #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   r_cnt;
  logic         r_ready;
  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;
  logic [1:0]   w_slot;

  assign w_push    = in_valid && r_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // Head is r_d0; a pop shifts r_d1 forward, so a push lands behind whatever remains.
  assign w_slot    = r_cnt - {1'b0, w_pop};

  assign in_ready  = r_ready;
  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = r_d0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_ready <= 1'b0;
      r_d0    <= '0;
      r_d1    <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt < 2'(DEPTH));
      if (w_pop) r_d0 <= r_d1;
      if (w_push) begin
        if (w_slot == 2'd0) r_d0 <= in_data;
        else                r_d1 <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into the ALU
// code/operand bundle and issues it through a 2-entry skid buffer.
module alu_decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_code,
  output logic [XLEN-1:0] out_rv1,
  output logic [XLEN-1:0] out_rv2,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic            w_unused;

  logic            w_legal;
  logic            w_alt;
  logic            w_imm_form;
  logic [2:0]      w_f3_op;
  logic [XLEN-1:0] w_rv1;
  logic [XLEN-1:0] w_rv2;
  issue_t          w_dec;
  issue_t          w_issue;

  assign w_opc    = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_shamt  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  // rs1 field is resolved upstream by the register-file read.
  assign w_unused = ^in_instr[19:15];

  always_comb begin
    w_legal    = 1'b0;
    w_alt      = 1'b0;
    w_imm_form = 1'b0;
    w_f3_op    = F3_ADD;
    w_rv1      = '0;
    w_rv2      = '0;
    case (w_opc)
      OPC_OP: begin
        w_legal = (w_f7 == F7_BASE) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)));
        w_alt   = in_instr[30];
        w_f3_op = w_f3;
        w_rv1   = in_rs1_val;
        w_rv2   = in_rs2_val;
      end
      OPC_OPIMM: begin
        w_imm_form = 1'b1;
        w_f3_op    = w_f3;
        w_rv1      = in_rs1_val;
        case (w_f3)
          F3_SLL: begin
            w_legal = (w_f7 == F7_BASE);
            w_rv2   = w_shamt;
          end
          F3_SR: begin
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            w_alt   = in_instr[30];
            w_rv2   = w_shamt;
          end
          default: begin
            w_legal = 1'b1;
            w_rv2   = w_imm_i;
          end
        endcase
      end
      OPC_LUI: begin
        w_legal    = 1'b1;
        w_imm_form = 1'b1;
        w_rv2      = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal    = 1'b1;
        w_imm_form = 1'b1;
        w_rv1      = in_pc;
        w_rv2      = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal bundles still flow in order but carry no operation or write.
  always_comb begin
    w_dec    = '0;
    w_dec.rd = in_instr[11:7];
    if (w_legal) begin
      w_dec.code = alu_code(w_imm_form, w_alt, w_f3_op);
      w_dec.rv1  = w_rv1;
      w_dec.rv2  = w_rv2;
      w_dec.we   = (in_instr[11:7] != 5'd0);
    end else begin
      w_dec.illegal = 1'b1;
    end
  end

  skid_buf2 #(
    .W     ($bits(issue_t)),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_issue)
  );

  assign out_code    = w_issue.code;
  assign out_rv1     = w_issue.rv1;
  assign out_rv2     = w_issue.rv2;
  assign out_rd      = w_issue.rd;
  assign out_we      = w_issue.we;
  assign out_illegal = w_issue.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed vectors plus randomized
// instructions checked against an independent RV32I decode model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_code;
  logic [31:0] out_rv1;
  logic [31:0] out_rv2;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  alu_decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_rv1     (out_rv1),
    .out_rv2     (out_rv2),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  code;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   accepted = 0;
  int   n_pops = 0;
  logic rnd_mode = 1'b0;
  logic ready_fixed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] code, input logic [31:0] rv1,
                              input logic [31:0] rv2, input logic [4:0] rd,
                              input logic we, input logic ill);
    exp_t e;
    e.code = code; e.rv1 = rv1; e.rv2 = rv2; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Reference decode: mnemonic lookup against the published code table.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  base [8];
    logic [6:0]  f7;
    int          f3;
    int          imm;
    logic        ok;
    logic [5:0]  c;
    logic [31:0] v1;
    logic [31:0] v2;
    exp_t        e;
    base = '{5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111};
    f7  = ins[31:25];
    f3  = int'(ins[14:12]);
    imm = int'(ins[31:20]);
    if (ins[31]) imm = imm - 4096;
    ok = 1'b1; c = '0; v1 = '0; v2 = '0;
    case (ins[6:0])
      7'h33: begin
        v1 = a; v2 = b;
        if (f7 == 7'h00)                 c = {1'b0, base[f3]};
        else if (f7 == 7'h20 && f3 == 0) c = 6'b011000;
        else if (f7 == 7'h20 && f3 == 5) c = 6'b011101;
        else                             ok = 1'b0;
      end
      7'h13: begin
        v1 = a;
        if (f3 == 1) begin
          v2 = 32'(ins[24:20]); c = 6'b101001; ok = (f7 == 7'h00);
        end else if (f3 == 5) begin
          v2 = 32'(ins[24:20]);
          if (f7 == 7'h00)      c = 6'b101101;
          else if (f7 == 7'h20) c = 6'b111101;
          else                  ok = 1'b0;
        end else begin
          v2 = imm; c = {1'b1, base[f3]};
        end
      end
      7'h37: begin c = 6'b101000; v2 = ins & 32'hFFFFF000; end
      7'h17: begin c = 6'b101000; v1 = pc; v2 = ins & 32'hFFFFF000; end
      default: ok = 1'b0;
    endcase
    if (ok) e = mk(c, v1, v2, ins[11:7], ins[11:7] != 0, 1'b0);
    else    e = mk(6'd0, 32'd0, 32'd0, ins[11:7], 1'b0, 1'b1);
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  // Monitor: pops and compares on every output transfer; checks hold under stall.
  exp_t held;
  logic hold_vld = 1'b0;
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    act = mk(out_code, out_rv1, out_rv2, out_rd, out_we, out_illegal);
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("hold_code", 32'(act.code), 32'(held.code));
        chk("hold_rv1", act.rv1, held.rv1);
        chk("hold_rv2", act.rv2, held.rv2);
        chk("hold_rd_we_ill", 32'({act.rd, act.we, act.ill}), 32'({held.rd, held.we, held.ill}));
      end
      if (out_valid && out_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("code", 32'(act.code), 32'(e.code));
          chk("rv1", act.rv1, e.rv1);
          chk("rv2", act.rv2, e.rv2);
          chk("rd", 32'(act.rd), 32'(e.rd));
          chk("we", 32'(act.we), 32'(e.we));
          chk("illegal", 32'(act.ill), 32'(e.ill));
        end
      end
      hold_vld = out_valid && !out_ready;
      held = act;
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n;
    in_instr = ins; in_pc = pc; in_rs1_val = a; in_rs2_val = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    accepted++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [31:0] ins;
    logic [6:0]  opcs [5];
    int sel;
    int k;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_code", 32'(out_code), 32'd0);
    chk("rst_rv1", out_rv1, 32'd0);
    chk("rst_rv2", out_rv2, 32'd0);
    chk("rst_rd_we_ill", 32'({out_rd, out_we, out_illegal}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    ready_fixed = 1'b1;
    @(posedge clk); #2;

    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(6'b001000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
    chk("latency_add", 32'(out_valid), 32'd1);
    send(32'hFFF00293, 32'h0, 32'd0, 32'd9, mk(6'b101000, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0));
    send(32'h4042D313, 32'h0, 32'h80000000, 32'd9, mk(6'b111101, 32'h80000000, 32'd4, 5'd6, 1'b1, 1'b0));
    send(32'h123453B7, 32'h0, 32'h55, 32'h66, mk(6'b101000, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0));
    send(32'h00001417, 32'h100, 32'h55, 32'h66, mk(6'b101000, 32'h100, 32'h1000, 5'd8, 1'b1, 1'b0));
    send(32'h00000000, 32'h0, 32'h11, 32'h22, mk(6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
    send(32'h00208033, 32'h0, 32'd1, 32'd2, mk(6'b001000, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0));
    send(32'h402091B3, 32'h0, 32'h11, 32'h22, mk(6'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1));
    send(32'h402081B3, 32'h0, 32'hA, 32'h3, mk(6'b011000, 32'hA, 32'h3, 5'd3, 1'b1, 1'b0));
    drain();

    // Backpressure: four queued with the consumer stalled.
    ready_fixed = 1'b0;
    @(posedge clk); #2;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(32'h00208033 | (32'(i + 1) << 7), 32'h0, 32'(i * 16), 32'd1,
               mk(6'b001000, 32'(i * 16), 32'd1, 5'(i + 1), 1'b1, 1'b0));
      end
    join_none
    repeat (6) @(negedge clk);
    chk("bp_accepted", 32'(accepted), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    p0 = n_pops;
    ready_fixed = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_pops", 32'(n_pops - p0), 32'd4);
    chk("bp_accepted_all", 32'(accepted), 32'd4);
    wait fork;
    drain();

    // Asynchronous reset with two entries buffered.
    ready_fixed = 1'b0;
    @(posedge clk); #2;
    send(32'h002081B3, 32'h0, 32'd1, 32'd1, mk(6'b001000, 32'd1, 32'd1, 5'd3, 1'b1, 1'b0));
    send(32'h00308233, 32'h0, 32'd2, 32'd2, mk(6'b001000, 32'd2, 32'd2, 5'd4, 1'b1, 1'b0));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_code", 32'(out_code), 32'd0);
    chk("async_rst_rv1", out_rv1, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_fixed = 1'b1;
    @(posedge clk); #2;
    chk("rerst_in_ready", 32'(in_ready), 32'd1);
    send(32'h001101B3, 32'h0, 32'd20, 32'd22, mk(6'b001000, 32'd20, 32'd22, 5'd3, 1'b1, 1'b0));
    chk("rerst_latency", 32'(out_valid), 32'd1);
    drain();

    // Randomized stream with random consumer stalls.
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h00};
    rnd_mode = 1'b1;
    @(posedge clk); #2;
    for (int t = 0; t < 300; t++) begin
      int idle;
      logic [31:0] pc, a, b;
      idle = $urandom_range(0, 2);
      repeat (idle) begin @(posedge clk); #2; end
      sel = $urandom_range(0, 9);
      ins = $urandom;
      if (sel <= 3)      ins[6:0] = opcs[0];
      else if (sel <= 6) ins[6:0] = opcs[1];
      else if (sel == 7) ins[6:0] = opcs[2];
      else if (sel == 8) ins[6:0] = opcs[3];
      if (sel <= 6) begin
        k = $urandom_range(0, 3);
        if (k <= 1)      ins[31:25] = 7'h00;
        else if (k == 2) ins[31:25] = 7'h20;
      end
      pc = $urandom; a = $urandom; b = $urandom;
      send(ins, pc, a, b, model(ins, pc, a, b));
    end
    rnd_mode = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
